// File: rtl/types_pkg.sv
// Shared rename/ROB types: the renamed-instruction record, the ROB entry and the tag space.
package types_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;
  localparam int PREG_W    = 7;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    pd_old;
    logic [31:0]          pc;
    logic [6:0]           Opcode;
  } rename_data;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
  } rob_entry;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order dispatch, out-of-order completion, in-order retire with free-list return.
// Optional ROB_PERF_CNT_EN adds retire_cnt/flush_cnt performance counters.
module rob
  import types_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  rename_data           data_in,
  output logic                 ready_in,
  input  logic                 cmp_valid,
  input  logic [ROB_TAG_W-1:0] cmp_tag,
  input  logic                 cmp_mispredict,
  output logic                 write_en,
  output logic [PREG_W-1:0]    rob_data_in,
  output logic                 mispredict,
  output logic [ROB_TAG_W-1:0] head_tag,
  output logic                 empty,
  output logic                 tag_err
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]          retire_cnt,
  output logic [15:0]          flush_cnt
`endif
);

  rob_entry             entries [DEPTH];
  logic [ROB_TAG_W-1:0] head, tail, flush_tag, head_nxt, br_off;
  logic [ROB_TAG_W:0]   count;
  logic                 dispatch, retire, cmp_hit;
  logic [DEPTH-1:0]     kill;
  logic                 unused_fields;

  assign unused_fields = ^{data_in.pc, data_in.Opcode};

  assign ready_in = (count != (ROB_TAG_W+1)'(DEPTH)) && !mispredict;
  assign empty    = (count == '0);
  assign head_tag = head;
  assign dispatch = valid_in && ready_in;
  assign retire   = entries[head].valid && entries[head].done;
  assign head_nxt = retire ? head + 1'b1 : head;
  assign br_off   = flush_tag - head;

  // Entries strictly younger than the branch, measured as age from head.
  always_comb begin
    kill = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      kill[i] = mispredict && ((ROB_TAG_W'(i) - head) > br_off);
  end

  assign cmp_hit = cmp_valid && entries[cmp_tag].valid && !kill[cmp_tag];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      flush_tag   <= '0;
      write_en    <= 1'b0;
      rob_data_in <= '0;
      mispredict  <= 1'b0;
      tag_err     <= 1'b0;
    end else begin
      write_en   <= retire && (entries[head].pd_new != '0);
      if (retire) rob_data_in <= entries[head].pd_old;
      mispredict <= cmp_hit && cmp_mispredict;
      if (cmp_hit && cmp_mispredict) flush_tag <= cmp_tag;
      if (dispatch && (data_in.rob_tag != tail)) tag_err <= 1'b1;

      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (dispatch && (tail == ROB_TAG_W'(i))) begin
          entries[i] <= '{valid: 1'b1, done: 1'b0,
                          pd_new: data_in.pd_new, pd_old: data_in.pd_old};
        end else begin
          if (cmp_hit && (cmp_tag == ROB_TAG_W'(i))) entries[i].done <= 1'b1;
          if ((retire && (head == ROB_TAG_W'(i))) || kill[i]) entries[i].valid <= 1'b0;
        end
      end

      head <= head_nxt;
      // Dispatch is blocked while mispredict is high, so the flush owns tail/count.
      // A branch retiring on the flush edge leaves nothing behind it.
      if (mispredict) begin
        tail  <= flush_tag + 1'b1;
        count <= (retire && (head == flush_tag)) ? '0
                 : {1'b0, flush_tag - head_nxt} + 1'b1;
      end else begin
        if (dispatch) tail <= tail + 1'b1;
        count <= count + (ROB_TAG_W+1)'(dispatch) - (ROB_TAG_W+1)'(retire);
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (retire)     retire_cnt <= retire_cnt + 1'b1;
      if (mispredict) flush_cnt  <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: a reference model queues expected free-list returns, a monitor checks them.
module tb_rob;
  import types_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  rename_data data_in = '0;
  logic       ready_in;
  logic       cmp_valid = 1'b0;
  logic [3:0] cmp_tag = '0;
  logic       cmp_mispredict = 1'b0;
  logic       write_en;
  logic [6:0] rob_data_in;
  logic       mispredict;
  logic [3:0] head_tag;
  logic       empty;
  logic       tag_err;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] retire_cnt;
  logic [15:0] flush_cnt;
`endif

  rob #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
    .cmp_mispredict(cmp_mispredict), .write_en(write_en),
    .rob_data_in(rob_data_in), .mispredict(mispredict), .head_tag(head_tag),
    .empty(empty), .tag_err(tag_err)
`ifdef ROB_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];

  // reference model
  logic [3:0] mhead = '0, mtail = '0;
  logic       mvalid[16];
  logic       mdone[16];
  logic [6:0] mpdnew[16];
  logic [6:0] mpdold[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (write_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL free_unexpected: got write_en=1 rob_data_in=%0d expected no return", rob_data_in);
      end else begin
        check("free_return", rob_data_in, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mhead = '0;
    mtail = '0;
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mdone[i]  = 1'b0;
    end
  endtask

  task automatic model_retire();
    while (mvalid[mhead] && mdone[mhead]) begin
      if (mpdnew[mhead] != 0) exp_q.push_back(mpdold[mhead]);
      mvalid[mhead] = 1'b0;
      mhead = mhead + 1'b1;
    end
  endtask

  task automatic dispatch(input logic [3:0] tag, input logic [6:0] pn, input logic [6:0] po);
    valid_in = 1'b1;
    data_in = '0;
    data_in.rob_tag = tag;
    data_in.pd_new = pn;
    data_in.pd_old = po;
    data_in.pc = 32'h1000 + {28'd0, tag};
    mvalid[mtail] = 1'b1;
    mdone[mtail]  = 1'b0;
    mpdnew[mtail] = pn;
    mpdold[mtail] = po;
    mtail = mtail + 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic complete(input logic [3:0] tag, input logic mp);
    cmp_valid = 1'b1;
    cmp_tag = tag;
    cmp_mispredict = mp;
    if (mvalid[tag]) mdone[tag] = 1'b1;
    model_retire();
    step();
    cmp_valid = 1'b0;
    cmp_mispredict = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    check("queue_empty_at_reset", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    model_clear();
    step();
  endtask

  initial begin
    model_clear();
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_ready_in", ready_in, 1);
    check("rst_empty", empty, 1);
    check("rst_head_tag", head_tag, 0);
    check("rst_write_en", write_en, 0);
    check("rst_rob_data_in", rob_data_in, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_tag_err", tag_err, 0);

    // single instruction, free-return latency
    dispatch(4'd0, 7'd33, 7'd5);
    check("t1_not_empty", empty, 0);
    complete(4'd0, 1'b0);
    check("t1_we_early", write_en, 0);
    step();
    check("t1_we", write_en, 1);
    check("t1_data", rob_data_in, 5);
    step();
    check("t1_we_pulse", write_en, 0);
    check("t1_empty", empty, 1);
    drain("t1_drain");
    do_reset();

    // fill, then out-of-order completion
    for (int i = 0; i < 16; i++) begin
      check("t2_ready_before_full", ready_in, 1);
      dispatch(mtail, 7'(40 + i), 7'(10 + i));
    end
    check("t2_ready_full", ready_in, 0);
    complete(4'd3, 1'b0);
    complete(4'd0, 1'b0);
    complete(4'd1, 1'b0);
    complete(4'd2, 1'b0);
    drain("t2_drain");
    check("t2_head_tag", head_tag, 4);
    check("t2_ready_after", ready_in, 1);
    do_reset();

    // store returns nothing
    dispatch(4'd0, 7'd0, 7'd9);
    complete(4'd0, 1'b0);
    step();
    check("t3_we", write_en, 0);
    step();
    check("t3_head_tag", head_tag, 1);
    check("t3_empty", empty, 1);
    do_reset();

    // mispredict flush
    for (int i = 0; i < 6; i++)
      dispatch(mtail, (i == 2) ? 7'd0 : 7'(50 + i), 7'(20 + i));
    complete(4'd2, 1'b1);
    check("t4_mp_high", mispredict, 1);
    check("t4_ready_blocked", ready_in, 0);
    step();
    check("t4_mp_pulse", mispredict, 0);
    check("t4_ready_back", ready_in, 1);
    for (int i = 3; i < 6; i++) mvalid[i] = 1'b0;
    mtail = 4'd3;
    complete(4'd3, 1'b0);
    complete(4'd4, 1'b0);
    complete(4'd5, 1'b0);
    complete(4'd0, 1'b0);
    complete(4'd1, 1'b0);
    drain("t4_drain");
    check("t4_empty", empty, 1);
    check("t4_head_tag", head_tag, 3);
    dispatch(4'd3, 7'd60, 7'd30);
    check("t4_tail3_no_tag_err", tag_err, 0);
    repeat (3) step();
    check("t4_new_entry_pending", empty, 0);
    complete(4'd3, 1'b0);
    drain("t4_drain2");
    do_reset();

    // tag mismatch is sticky
    dispatch(4'd7, 7'd61, 7'd31);
    check("t5_tag_err", tag_err, 1);
    complete(4'd0, 1'b0);
    drain("t5_drain");
    check("t5_tag_err_sticky", tag_err, 1);

    // asynchronous reset with done entries behind an unfinished head
    for (int i = 0; i < 5; i++) dispatch(mtail, 7'(70 + i), 7'(40 + i));
    for (int i = 1; i < 5; i++) complete(mhead + 4'(i), 1'b0);
    repeat (2) step();
    check("t6_pending", empty, 0);
    check("t6_queue", exp_q.size(), 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t6_ready_in", ready_in, 1);
    check("t6_empty", empty, 1);
    check("t6_head_tag", head_tag, 0);
    check("t6_write_en", write_en, 0);
    check("t6_rob_data_in", rob_data_in, 0);
    check("t6_mispredict", mispredict, 0);
    check("t6_tag_err", tag_err, 0);
    repeat (2) step();
    reset = 1'b0;
    model_clear();
    repeat (6) step();
    check("t6_still_empty", empty, 1);
    check("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
